// File: rtl/bob_indir_reader.sv
// In-order reader of the BOB indirect-target store: polls an entry until ready, hands it off, then clears its ready bit.
// Latency 2 cycles from accept to out_valid when the entry is already ready; one entry per 3 cycles at best.
module bob_indir_reader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 65,
    parameter int CNT_WIDTH  = 8,
    parameter int STALL_MAX  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rd_clkEn,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_wen,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic                  stall_timeout
);
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;
    localparam logic [CNT_WIDTH-1:0] STALL_LIM = CNT_WIDTH'(STALL_MAX);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic                  stall_timeout_q, stall_timeout_d;

    // The store registers rd_addr, so in WAIT we keep presenting cur_addr to hold it there.
    assign req_ready = (state_q == IDLE) && !flush && !rst;
    assign rd_clkEn  = (state_q == IDLE) ? req_valid : (state_q == WAIT);
    assign rd_addr   = (state_q == IDLE) ? req_addr : cur_addr_q;
    assign clr_wen   = (state_q == OUT) && out_ready && !flush && !rst;
    assign clr_addr  = out_addr_q;

    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_data      = out_data_q;
    assign stall_cnt     = stall_cnt_q;
    assign stall_timeout = stall_timeout_q;

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        out_addr_d      = out_addr_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        stall_cnt_d     = stall_cnt_q;
        stall_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cur_addr_d  = req_addr;
                    stall_cnt_d = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (rd_ready) begin
                    out_data_d  = rd_data;
                    out_addr_d  = cur_addr_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    if (stall_cnt_q != CNT_SAT) begin
                        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
                    end
                    // Fires only on the transition into the limit, never while parked there.
                    stall_timeout_d = (stall_cnt_d == STALL_LIM) && (stall_cnt_q != STALL_LIM);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d         = IDLE;
            out_valid_d     = 1'b0;
            stall_cnt_d     = '0;
            stall_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cur_addr_q      <= '0;
            out_addr_q      <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            out_addr_q      <= out_addr_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end
endmodule

// File: tb/tb_bob_indir_reader.sv
// Bench for bob_indir_reader: behavioural BOB store, directed scenarios, then randomized requests against a scoreboard.
module tb_bob_indir_reader;
    localparam int AW = 6;
    localparam int DW = 65;
    localparam int CW = 8;
    localparam int SMAX = 10;

    logic          clk = 1'b0;
    logic          rst, flush, req_valid, req_ready, rd_clkEn, rd_ready, clr_wen;
    logic          out_valid, out_ready, stall_timeout;
    logic [AW-1:0] req_addr, rd_addr, clr_addr, out_addr;
    logic [DW-1:0] rd_data, out_data;
    logic [CW-1:0] stall_cnt;

    bob_indir_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STALL_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rd_clkEn(rd_clkEn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .clr_addr(clr_addr), .clr_wen(clr_wen),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
        .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    // Store model: registered read address, data write sets ready, indirect clear applied last.
    logic [DW-1:0] mem [64];
    logic          srdy [64];
    logic [AW-1:0] areg;
    logic          wr_en, wr_rdy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    assign rd_data  = mem[areg];
    assign rd_ready = srdy[areg];
    always @(posedge clk) begin
        if (rd_clkEn) areg <= rd_addr;
        if (wr_en) begin
            mem[wr_addr]  <= wr_data;
            srdy[wr_addr] <= wr_rdy;
        end
        if (clr_wen) srdy[clr_addr] <= 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            k;
        int            acc;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;
    int tmo_seen = 0;
    bit rnd_mode = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_mode) out_ready = ($urandom % 3) != 0;
    end

    // Monitor: handshake rule, stability while stalled, latency and payload from the scoreboard.
    bit            hold_prev = 1'b0;
    bit            ov_prev = 1'b0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    always @(negedge clk) begin
        if (!rst) begin
            automatic bit hs = out_valid && out_ready && !flush;
            automatic exp_t e;
            chk("clr_wen_rule", 128'(clr_wen), 128'(hs));
            if (out_valid) chk("req_ready_busy", 128'(req_ready), 128'(0));
            if (hold_prev) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_addr", 128'(out_addr), 128'(h_addr));
                chk("hold_data", 128'(out_data), 128'(h_data));
            end
            if (out_valid && !ov_prev && q.size() > 0)
                chk("latency", 128'(cyc - q[0].acc), 128'(q[0].k + 2));
            if (hs) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = q.pop_front();
                    chk("out_addr", 128'(out_addr), 128'(e.addr));
                    chk("out_data", 128'(out_data), 128'(e.data));
                    chk("clr_addr", 128'(clr_addr), 128'(e.addr));
                    chk("stall_cnt_at_out", 128'(stall_cnt), 128'(e.k));
                end
            end
            hold_prev = out_valid && !out_ready && !flush;
            h_addr = out_addr;
            h_data = out_data;
            ov_prev = out_valid;
            if (stall_timeout) tmo_seen++;
        end else begin
            hold_prev = 1'b0;
            ov_prev = 1'b0;
        end
    end

    // k < 0: entry is never made ready; otherwise the ready-setting write lands k cycles after accept.
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input int k, input bit push);
        int w = 0;
        int n;
        exp_t e;
        while (!req_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            fail_now("req_ready_wait");
            return;
        end
        n = (k < 0) ? 0 : k;
        req_valid = 1'b1;
        req_addr = a;
        wr_addr = a;
        wr_data = d;
        wr_rdy = 1'b1;
        if (push) begin
            e.addr = a; e.data = d; e.k = k; e.acc = cyc;
            q.push_back(e);
        end
        for (int j = 0; j <= n; j++) begin
            wr_en = (k >= 0) && (j == k);
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_ov();
        int w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!out_valid) fail_now("out_valid_wait");
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((q.size() != 0 || !req_ready) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_queue_empty", 128'(q.size()), 128'(0));
    endtask

    task automatic model_clear(input logic [AW-1:0] a);
        wr_en = 1'b1; wr_addr = a; wr_rdy = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_rdy = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_addr"}, 128'(out_addr), 128'(0));
        chk({tag, "_out_data"}, 128'(out_data), 128'(0));
        chk({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(0));
        chk({tag, "_stall_timeout"}, 128'(stall_timeout), 128'(0));
        chk({tag, "_clr_wen"}, 128'(clr_wen), 128'(0));
        chk({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int k, pulses, cnt_at, badv, exp_tmo, tmo0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            srdy[i] = 1'b0;
        end
        areg = '0;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; out_ready = 1'b1;
        wr_en = 1'b0; wr_rdy = 1'b1; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;

        // Ready entry: out_valid two cycles after accept, cleared on the handshake.
        issue(6'd5, 65'h1_DEAD_BEEF_0000_0005, 0, 1'b1);
        wait_drain();

        // Entry made ready four cycles after the request.
        issue(6'd3, 65'h0_1234_5678_9ABC_DEF0, 4, 1'b1);
        wait_drain();

        // Never-ready entry: one timeout pulse at the limit, counter saturates.
        issue(6'd7, '0, -1, 1'b0);
        pulses = 0; cnt_at = 0; badv = 0;
        repeat (300) begin
            @(negedge clk);
            if (stall_timeout) begin
                pulses++;
                cnt_at = int'(stall_cnt);
            end
            if (out_valid) badv++;
        end
        chk("timeout_pulses", 128'(pulses), 128'(1));
        chk("timeout_at_cnt", 128'(cnt_at), 128'(SMAX));
        chk("stall_saturate", 128'(stall_cnt), 128'(255));
        chk("no_out_while_stalled", 128'(badv), 128'(0));
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_stall_cnt", 128'(stall_cnt), 128'(0));
        chk("flush_req_ready", 128'(req_ready), 128'(1));
        @(posedge clk); #1;

        // Consumer holds off for six cycles in OUT.
        out_ready = 1'b0;
        issue(6'd9, 65'h1_0000_0000_CAFE_0009, 1, 1'b1);
        wait_ov();
        repeat (6) begin
            @(negedge clk);
            chk("stalled_clr_wen", 128'(clr_wen), 128'(0));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();

        // Flush while waiting, then flush colliding with an accept in OUT.
        issue(6'd11, '0, -1, 1'b0);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_wait_out_valid", 128'(out_valid), 128'(0));
        chk("flush_wait_stall_cnt", 128'(stall_cnt), 128'(0));
        chk("flush_wait_req_ready", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(6'd12, 65'h0_AAAA_BBBB_CCCC_DDDD, 0, 1'b0);
        wait_ov();
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_clr_wen", 128'(clr_wen), 128'(0));
        chk("flush_out_req_ready", 128'(req_ready), 128'(0));
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_out_out_valid", 128'(out_valid), 128'(0));
        chk("flush_out_req_ready_after", 128'(req_ready), 128'(1));
        chk("flush_out_entry_ready", 128'(srdy[12]), 128'(1));
        @(posedge clk); #1;
        model_clear(6'd12);

        // Reset mid-handoff, then a read of the top index.
        out_ready = 1'b0;
        issue(6'd20, 65'h1_5555_6666_7777_8888, 0, 1'b0);
        wait_ov();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        model_clear(6'd20);
        out_ready = 1'b1;
        issue(6'd63, 65'h1_FFFF_0000_FFFF_003F, 2, 1'b1);
        wait_drain();

        // Randomized traffic with a random consumer.
        rnd_mode = 1'b1;
        tmo0 = tmo_seen;
        exp_tmo = 0;
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom % 64);
            d[31:0] = $urandom;
            d[63:32] = $urandom;
            d[64] = 1'($urandom & 1);
            k = int'($urandom % 13);
            if (k >= SMAX) exp_tmo++;
            issue(a, d, k, 1'b1);
        end
        wait_drain();
        chk("random_timeouts", 128'(tmo_seen - tmo0), 128'(exp_tmo));
        rnd_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
